// File: rtl/hub75_pkg.sv
// hub75_pkg: types and defaults shared by the HUB75 blocks
// (hub75_output, frame_manager, hub75_rx).
package hub75_pkg;

    // One HUB75 pixel as it appears on a colour pin group: {r,g,b}.
    typedef logic [2:0] rgb_t;

    localparam int RGB_W             = 3;
    localparam int SCAN_RATE_DEFAULT = 32;
    localparam int HUB75_ADDR_W      = $clog2(SCAN_RATE_DEFAULT);
    localparam int RX_SYNC_DEFAULT   = 2;

endpackage

// File: rtl/hub75_rx_sync.sv
// hub75_rx_sync: multi-flop synchronizer for asynchronous HUB75 pins.
// With EDGE=1 the output is a one-cycle rising-edge pulse per bit, taken
// from one further registered copy of the synchronized value; with EDGE=0
// the output is the synchronized level itself. All flops clear on reset,
// so a pin already high at reset release is reported as a rising edge.
module hub75_rx_sync
    import hub75_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = RX_SYNC_DEFAULT,
    parameter bit EDGE   = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // Shift the raw pins through the synchronizer chain.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic [WIDTH-1:0] r_prev;

            // Keep last cycle's synchronized value for edge detection.
            always_ff @(posedge clk_in) begin
                if (!rst_in) r_prev <= '0;
                else         r_prev <= r_stage[STAGES-1];
            end

            assign o_q = r_stage[STAGES-1] & ~r_prev;
        end else begin : g_level
            assign o_q = r_stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 capture/decoder. Oversamples the panel pins on clk_in,
// rebuilds each shifted row pair and offers it on a valid/ready stream.
// Optional build macro HUB75_RX_OE_MEAS_EN adds row_on_cycles, the number
// of clk_in cycles OE was low between consecutive latches.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int NUM_COLS    = 64,
    parameter int SCAN_RATE   = 32,
    parameter int SYNC_STAGES = RX_SYNC_DEFAULT,
    localparam int ADDR_W     = $clog2(SCAN_RATE),
    localparam int ROW_W      = NUM_COLS * RGB_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              hub75_clk_in,
    input  logic [2:0]        hub75_rgb0_in,
    input  logic [2:0]        hub75_rgb1_in,
    input  logic              hub75_latch_in,
    input  logic              hub75_oe_in,
    input  logic [ADDR_W-1:0] hub75_addr_in,
    output logic [ROW_W-1:0]  row_rgb0,
    output logic [ROW_W-1:0]  row_rgb1,
    output logic [ADDR_W-1:0] row_addr,
`ifdef HUB75_RX_OE_MEAS_EN
    output logic [15:0]       row_on_cycles,
`endif
    output logic              row_valid,
    input  logic              row_ready,
    output logic              row_err,
    output logic              overrun
);

    localparam int CNT_W   = $clog2(NUM_COLS + 1);
    localparam int BUS_W   = 2 * RGB_W + ADDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_COLS);

    // Shift-side state: a row is being shifted whenever the count is nonzero.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_SHIFT   = 1'b1;
    // Output holding register state, independent of the shift side.
    localparam logic [0:0] HOLD_EMPTY = 1'b0;
    localparam logic [0:0] HOLD_FULL  = 1'b1;

    logic [1:0]        w_ctlRise;
    logic              w_clkRise;
    logic              w_latchRise;
    logic [BUS_W-1:0]  w_bus;
    rgb_t              w_rgb0;
    rgb_t              w_rgb1;
    logic [ADDR_W-1:0] w_addr;

    logic [CNT_W-1:0]  r_pixCnt;
    logic              r_tooLong;
    logic [0:0]        r_shiftState;
    logic [0:0]        r_holdState;
    logic [ROW_W-1:0]  r_buf0;
    logic [ROW_W-1:0]  r_buf1;
    logic [ROW_W-1:0]  r_holdRgb0;
    logic [ROW_W-1:0]  r_holdRgb1;
    logic [ADDR_W-1:0] r_holdAddr;
    logic              r_rowErr;
    logic              r_overrun;

    logic              w_rowGood;
    logic              w_accept;
    logic              w_load;
    logic              w_wrEn;
    logic [CNT_W-1:0]  w_wrIdx;

    hub75_rx_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .EDGE(1'b1)) u_ctlSync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_d    ({hub75_latch_in, hub75_clk_in}),
        .o_q    (w_ctlRise)
    );

    hub75_rx_sync #(.WIDTH(BUS_W), .STAGES(SYNC_STAGES), .EDGE(1'b0)) u_busSync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_d    ({hub75_addr_in, hub75_rgb1_in, hub75_rgb0_in}),
        .o_q    (w_bus)
    );

    assign w_clkRise   = w_ctlRise[0];
    assign w_latchRise = w_ctlRise[1];
    assign w_rgb0      = w_bus[RGB_W-1:0];
    assign w_rgb1      = w_bus[2*RGB_W-1:RGB_W];
    assign w_addr      = w_bus[BUS_W-1:2*RGB_W];

    // A latch delivers a row only for exactly NUM_COLS clean shifts; a
    // zero-pixel latch lands in IDLE and is an error too.
    assign w_rowGood = (r_shiftState == ST_SHIFT) && (r_pixCnt == FULL_CNT) && !r_tooLong;
    assign w_accept  = (r_holdState == HOLD_FULL) && row_ready;
    assign w_load    = w_latchRise && w_rowGood && ((r_holdState == HOLD_EMPTY) || w_accept);

    // A clock edge coinciding with a latch starts the next row at pixel 0.
    assign w_wrEn  = w_clkRise && (w_latchRise || (r_pixCnt < FULL_CNT));
    assign w_wrIdx = w_latchRise ? '0 : r_pixCnt;

    // Track the pixel count, the too-long flag and the shift state.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_pixCnt     <= '0;
            r_tooLong    <= 1'b0;
            r_shiftState <= ST_IDLE;
        end else if (w_latchRise) begin
            r_tooLong <= 1'b0;
            if (w_clkRise) begin
                r_pixCnt     <= CNT_W'(1);
                r_shiftState <= ST_SHIFT;
            end else begin
                r_pixCnt     <= '0;
                r_shiftState <= ST_IDLE;
            end
        end else if (w_clkRise) begin
            if (r_pixCnt < FULL_CNT) begin
                r_pixCnt     <= r_pixCnt + CNT_W'(1);
                r_shiftState <= ST_SHIFT;
            end else begin
                r_tooLong <= 1'b1;
            end
        end
    end

    // Pixel buffer; only read after every slot of a good row was written, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (w_wrEn) begin
            r_buf0[RGB_W*w_wrIdx +: RGB_W] <= w_rgb0;
            r_buf1[RGB_W*w_wrIdx +: RGB_W] <= w_rgb1;
        end
    end

    // Holding register, handshake, error pulse and sticky overrun.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_holdState <= HOLD_EMPTY;
            r_holdRgb0  <= '0;
            r_holdRgb1  <= '0;
            r_holdAddr  <= '0;
            r_rowErr    <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rowErr <= w_latchRise && !w_rowGood;
            if (w_latchRise && w_rowGood && !w_load) r_overrun <= 1'b1;
            if (w_load) begin
                r_holdRgb0  <= r_buf0;
                r_holdRgb1  <= r_buf1;
                r_holdAddr  <= w_addr;
                r_holdState <= HOLD_FULL;
            end else if (w_accept) begin
                r_holdState <= HOLD_EMPTY;
            end
        end
    end

`ifdef HUB75_RX_OE_MEAS_EN
    logic        w_oe;
    logic [15:0] r_oeCnt;
    logic [15:0] r_holdOnCycles;

    hub75_rx_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE(1'b0)) u_oeSync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_d    (hub75_oe_in),
        .o_q    (w_oe)
    );

    // Count OE-low cycles since the last latch, saturating, and capture with the row.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_oeCnt        <= '0;
            r_holdOnCycles <= '0;
        end else begin
            if (w_latchRise)                    r_oeCnt <= '0;
            else if (!w_oe && r_oeCnt != 16'hFFFF) r_oeCnt <= r_oeCnt + 16'd1;
            if (w_load) r_holdOnCycles <= r_oeCnt;
        end
    end

    assign row_on_cycles = r_holdOnCycles;
`endif

    assign row_rgb0  = r_holdRgb0;
    assign row_rgb1  = r_holdRgb1;
    assign row_addr  = r_holdAddr;
    assign row_valid = (r_holdState == HOLD_FULL);
    assign row_err   = r_rowErr;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: directed self-checking bench for hub75_rx. Drives HUB75 pins
// at clk_in/6 and compares outputs against hand-computed rows.
// Build with HUB75_RX_OE_MEAS_EN defined to also exercise row_on_cycles.
module tb_hub75_rx;

    localparam int NUM_COLS = 64;
    localparam int ADDR_W   = 5;
    localparam int ROW_W    = NUM_COLS * 3;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              hub75_clk_in;
    logic [2:0]        hub75_rgb0_in;
    logic [2:0]        hub75_rgb1_in;
    logic              hub75_latch_in;
    logic              hub75_oe_in;
    logic [ADDR_W-1:0] hub75_addr_in;
    logic [ROW_W-1:0]  row_rgb0;
    logic [ROW_W-1:0]  row_rgb1;
    logic [ADDR_W-1:0] row_addr;
    logic              row_valid;
    logic              row_ready;
    logic              row_err;
    logic              overrun;
`ifdef HUB75_RX_OE_MEAS_EN
    logic [15:0]       row_on_cycles;
`endif

    int checks    = 0;
    int failures  = 0;
    int errCycles = 0;
    int errBase   = 0;

    hub75_rx #(.NUM_COLS(NUM_COLS), .SCAN_RATE(32), .SYNC_STAGES(2)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hub75_clk_in   (hub75_clk_in),
        .hub75_rgb0_in  (hub75_rgb0_in),
        .hub75_rgb1_in  (hub75_rgb1_in),
        .hub75_latch_in (hub75_latch_in),
        .hub75_oe_in    (hub75_oe_in),
        .hub75_addr_in  (hub75_addr_in),
        .row_rgb0       (row_rgb0),
        .row_rgb1       (row_rgb1),
        .row_addr       (row_addr),
`ifdef HUB75_RX_OE_MEAS_EN
        .row_on_cycles  (row_on_cycles),
`endif
        .row_valid      (row_valid),
        .row_ready      (row_ready),
        .row_err        (row_err),
        .overrun        (overrun)
    );

    // Free-running system clock.
    always #5 clk_in = ~clk_in;

    // Count cycles with row_err high, sampled on the falling edge.
    always @(negedge clk_in) begin
        if (row_err === 1'b1) errCycles++;
    end

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [2:0] pixVal(input int k, input int seed, input bit lower);
        logic [2:0] v;
        v = 3'((k + seed) % 8);
        if (lower) v = 3'd7 - v;
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] expRow(input int seed, input bit lower);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_COLS; k++) r[3*k +: 3] = pixVal(k, seed, lower);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [ROW_W-1:0] observed,
                               input logic [ROW_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Shift n pixels: 3 clk_in cycles low with data set up, then 3 cycles high.
    task automatic shiftPixels(input int n, input int seed);
        for (int k = 0; k < n; k++) begin
            hub75_clk_in  = 1'b0;
            hub75_rgb0_in = pixVal(k, seed, 1'b0);
            hub75_rgb1_in = pixVal(k, seed, 1'b1);
            repeat (3) @(negedge clk_in);
            hub75_clk_in = 1'b1;
            repeat (3) @(negedge clk_in);
        end
    endtask

    // Present addr, then pulse latch for 3 cycles and leave 3 idle cycles.
    task automatic pulseLatch(input logic [ADDR_W-1:0] addr);
        hub75_addr_in = addr;
        @(negedge clk_in);
        hub75_latch_in = 1'b1;
        repeat (3) @(negedge clk_in);
        hub75_latch_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic applyStimulus(input int n, input logic [ADDR_W-1:0] addr, input int seed);
        shiftPixels(n, seed);
        pulseLatch(addr);
    endtask

    // Single-cycle consumer acceptance.
    task automatic acceptRow();
        row_ready = 1'b1;
        @(negedge clk_in);
        row_ready = 1'b0;
    endtask

    // Directed sequence covering capture, errors, overrun, reset and back-to-back rows.
    initial begin
        rst_in = 1'b0;
        hub75_clk_in = 1'b0;
        hub75_rgb0_in = '0;
        hub75_rgb1_in = '0;
        hub75_latch_in = 1'b0;
        hub75_oe_in = 1'b1;
        hub75_addr_in = '0;
        row_ready = 1'b0;
        repeat (4) @(negedge clk_in);
        checkOutput("reset_valid", ROW_W'(row_valid), '0);
        checkOutput("reset_err", ROW_W'(row_err), '0);
        checkOutput("reset_overrun", ROW_W'(overrun), '0);
        checkOutput("reset_addr", ROW_W'(row_addr), '0);
        checkOutput("reset_rgb0", row_rgb0, '0);
        checkOutput("reset_rgb1", row_rgb1, '0);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Full row, addr 5, with latch-to-valid latency checked.
        shiftPixels(NUM_COLS, 0);
        hub75_addr_in = 5'd5;
        @(negedge clk_in);
        hub75_latch_in = 1'b1;
        repeat (2) @(negedge clk_in);
        checkOutput("latency_early", ROW_W'(row_valid), '0);
        @(negedge clk_in);
        checkOutput("latency_valid", ROW_W'(row_valid), ROW_W'(1));
        hub75_latch_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("row1_addr", ROW_W'(row_addr), ROW_W'(5));
        checkOutput("row1_rgb0", row_rgb0, expRow(0, 1'b0));
        checkOutput("row1_rgb1", row_rgb1, expRow(0, 1'b1));
        checkOutput("row1_no_err", ROW_W'(errCycles), '0);
        acceptRow();
        checkOutput("accept_clears", ROW_W'(row_valid), '0);

        // Short row: one-cycle error, nothing delivered.
        errBase = errCycles;
        applyStimulus(NUM_COLS - 1, 5'd3, 1);
        repeat (2) @(negedge clk_in);
        checkOutput("short_err_pulse", ROW_W'(errCycles - errBase), ROW_W'(1));
        checkOutput("short_no_valid", ROW_W'(row_valid), '0);

        // Long row: one-cycle error, nothing delivered.
        errBase = errCycles;
        applyStimulus(NUM_COLS + 6, 5'd4, 2);
        repeat (2) @(negedge clk_in);
        checkOutput("long_err_pulse", ROW_W'(errCycles - errBase), ROW_W'(1));
        checkOutput("long_no_valid", ROW_W'(row_valid), '0);

        // Two rows with no consumer: first held, second dropped.
        errBase = errCycles;
        applyStimulus(NUM_COLS, 5'd1, 3);
        applyStimulus(NUM_COLS, 5'd2, 4);
        checkOutput("ovr_flag", ROW_W'(overrun), ROW_W'(1));
        checkOutput("ovr_valid", ROW_W'(row_valid), ROW_W'(1));
        checkOutput("ovr_addr_held", ROW_W'(row_addr), ROW_W'(1));
        checkOutput("ovr_rgb0_held", row_rgb0, expRow(3, 1'b0));
        checkOutput("ovr_rgb1_held", row_rgb1, expRow(3, 1'b1));
        checkOutput("ovr_no_err", ROW_W'(errCycles - errBase), '0);
        acceptRow();
        checkOutput("ovr_accept_drops", ROW_W'(row_valid), '0);

        // Reset in the middle of a row; everything returns to zero.
        shiftPixels(30, 5);
        rst_in = 1'b0;
        hub75_clk_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("midrst_valid", ROW_W'(row_valid), '0);
        checkOutput("midrst_err", ROW_W'(row_err), '0);
        checkOutput("midrst_overrun", ROW_W'(overrun), '0);
        checkOutput("midrst_addr", ROW_W'(row_addr), '0);
        checkOutput("midrst_rgb0", row_rgb0, '0);
        checkOutput("midrst_rgb1", row_rgb1, '0);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        errBase = errCycles;
        applyStimulus(NUM_COLS, 5'd7, 6);
        checkOutput("postrst_valid", ROW_W'(row_valid), ROW_W'(1));
        checkOutput("postrst_addr", ROW_W'(row_addr), ROW_W'(7));
        checkOutput("postrst_rgb0", row_rgb0, expRow(6, 1'b0));
        checkOutput("postrst_rgb1", row_rgb1, expRow(6, 1'b1));
        checkOutput("postrst_no_err", ROW_W'(errCycles - errBase), '0);
        acceptRow();

        // Back-to-back: second latch lands in the same cycle the first row is accepted.
        applyStimulus(NUM_COLS, 5'd1, 8);
        checkOutput("b2b_first_addr", ROW_W'(row_addr), ROW_W'(1));
        shiftPixels(NUM_COLS, 9);
        hub75_addr_in = 5'd2;
        @(negedge clk_in);
        hub75_latch_in = 1'b1;
        repeat (2) @(negedge clk_in);
        row_ready = 1'b1;
        @(negedge clk_in);
        row_ready = 1'b0;
        checkOutput("b2b_valid", ROW_W'(row_valid), ROW_W'(1));
        checkOutput("b2b_addr", ROW_W'(row_addr), ROW_W'(2));
        checkOutput("b2b_rgb0", row_rgb0, expRow(9, 1'b0));
        checkOutput("b2b_no_overrun", ROW_W'(overrun), '0);
        hub75_latch_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("b2b_valid_held", ROW_W'(row_valid), ROW_W'(1));
        acceptRow();
        checkOutput("b2b_done", ROW_W'(row_valid), '0);

`ifdef HUB75_RX_OE_MEAS_EN
        // OE held low for exactly 200 clk_in cycles inside one row.
        shiftPixels(32, 10);
        hub75_oe_in = 1'b0;
        repeat (200) @(negedge clk_in);
        hub75_oe_in = 1'b1;
        shiftPixels(32, 10);
        pulseLatch(5'd3);
        checkOutput("oe_valid", ROW_W'(row_valid), ROW_W'(1));
        checkOutput("oe_on_cycles", ROW_W'(row_on_cycles), ROW_W'(200));
        acceptRow();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- HUB75 capture/decoder: the receive end of the panel interface driven by hub75_output.
- Oversamples the HUB75 pins (led_clk, rgb0, rgb1, latch, OE, addr) on the system clock.
- Reassembles each shifted row pair and presents it on a valid/ready stream.
- Used for loopback self-test on the board and as the checker back-end in hub75 benches.

Parameters:
NUM_COLS, 64, pixels shifted per row before a latch
SCAN_RATE, 32, number of row addresses; addr width = $clog2(SCAN_RATE)
SYNC_STAGES, 2, synchronizer flops on every HUB75 input (min 2)

Ports:
clk_in  input  1  system clock; HUB75 inputs are oversampled on it
rst_in  input  1  synchronous, active-low reset
hub75_clk_in  input  1  panel shift clock; data is sampled on its rising edge
hub75_rgb0_in  input  3  upper-half pixel {r,g,b}
hub75_rgb1_in  input  3  lower-half pixel {r,g,b}
hub75_latch_in  input  1  row latch; the rising edge commits the row
hub75_oe_in  input  1  output enable, active-low
hub75_addr_in  input  $clog2(SCAN_RATE)  row address
row_rgb0  output  NUM_COLS*3  captured upper row; pixel k at bits [3k+2:3k]
row_rgb1  output  NUM_COLS*3  captured lower row, same packing
row_addr  output  $clog2(SCAN_RATE)  addr sampled at the latch edge
row_valid  output  1  captured row available
row_ready  input  1  consumer accepts the row when row_valid && row_ready
row_err  output  1  one-cycle pulse: latch seen with pixel count != NUM_COLS
overrun  output  1  sticky; a row was dropped because the output was still full

Behaviour:
- Input synchronizers:
  - All inputs pass through SYNC_STAGES flops; edge detect uses one further registered copy.
  - Latency from a pin change to detection is SYNC_STAGES+1 cycles.
  - HUB75 clock must be at most clk_in/4; faster clocks are not supported.
- Shift capture:
  - On each detected hub75_clk rising edge with pix_cnt < NUM_COLS: store rgb0/rgb1 (sampled in the same synchronized cycle) at index pix_cnt, then pix_cnt++.
  - Edges at pix_cnt == NUM_COLS are ignored; pix_cnt saturates and a flag marks the row too long.
- States:
  - IDLE: pix_cnt == 0.
  - SHIFT: pix_cnt > 0.
  - Output holding register: HOLD_EMPTY / HOLD_FULL, tracked independently of the shift state.
- Latch rising edge:
  - If pix_cnt == NUM_COLS and not too long, and the holding register is empty or is being accepted this cycle: copy the buffer and addr into the holding register; row_valid=1 next cycle.
  - If pix_cnt == NUM_COLS and not too long, but the holding register is full and not accepted: drop the row and set overrun=1 (cleared only by reset).
  - Otherwise (pixel count wrong, including a zero-pixel latch): pulse row_err for 1 cycle and deliver no row.
  - In every case pix_cnt returns to 0 and the flag clears; go to IDLE.
- Clock and latch edges in the same cycle: the latch is processed on the existing count. The clock edge becomes pixel 0 of the next row (pix_cnt=1).
- Handshake:
  - row_valid stays high until accepted.
  - row_* outputs are stable while row_valid=1.
  - Acceptance clears row_valid next cycle unless a new row loads in the same cycle, in which case row_valid stays 1.
- OE is ignored for capture (unless the optional feature is enabled).
- Reset (rst_in==0 at posedge), including mid-row:
  - pix_cnt=0; synchronizers cleared to 0.
  - row_valid=0, row_err=0, overrun=0, row_addr=0, row_rgb0/1=0.
  - The partial row is discarded.
  - The first edge check after reset uses the cleared history, so a pin held high is seen as a rising edge.

Optional Feature:
- HUB75_RX_OE_MEAS_EN defined:
  - Adds output row_on_cycles (16 bits).
  - Counts clk_in cycles with synchronized OE low since the previous latch edge, saturating at 16'hFFFF.
  - The value is captured into the holding register alongside the row and is stable while row_valid=1; the counter resets at each latch.
  - Reset value is 0.
- Not defined: the port is absent and OE is unused.

Decomposition:
- hub75_pkg:
  - rgb_t (3-bit {r,g,b}).
  - Constants HUB75_ADDR_W = $clog2(SCAN_RATE) and RX_SYNC_DEFAULT.
  - Shared with hub75_output and frame_manager.
- One sub-module: hub75_rx_sync (parameterized-width SYNC_STAGES synchronizer plus edge detector), instantiated for the clock, latch and OE bits and for the data/addr buses.

Test Plan:
- Shift 64 pixels, pixel k rgb0=k%8, rgb1=7-(k%8), addr=5, then latch -> row_valid after sync latency; row_rgb0[k]==k%8, row_rgb1[k]==7-(k%8), row_addr==5.
- Shift 63 pixels then latch -> row_err pulses 1 cycle, row_valid stays 0. Shift 70 then latch -> row_err again, pixels 64..69 ignored.
- row_ready=0; send two full rows (addr 1, then 2) -> first row held unchanged, overrun=1. Raise row_ready -> row addr 1 is delivered and row_valid drops.
- row_ready held 1 with back-to-back rows; the latch coincides with acceptance -> no overrun, row_valid stays high, addr advances 1->2.
- Assert rst_in=0 after 30 pixels, release, then shift 64 and latch -> one clean row, no row_err, all outputs 0 during reset.
- With HUB75_RX_OE_MEAS_EN: hold OE low for 200 clk_in cycles within a row -> row_on_cycles==200. Without the macro -> builds, and the port is absent.
